ysyx_220053_mdu: RTL and testbench
==================================

YSYX_220053_MDU -- requirements
Module: ysyx_220053_mdu

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request strobe; sampled only in IDLE.
REQ-005 mdu_op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 op_w  input  1  word variant; honoured for ops 0 and 4-7, ignored for ops 1-3.
REQ-007 inputa  input  64  operand A (rs1 / dividend).
REQ-008 inputb  input  64  operand B (rs2 / divisor).
REQ-009 mwb_block  input  1  downstream stall; result not consumed while high.
REQ-010 alu_busy  output  1  high from the cycle after accept until the result is consumed.
REQ-011 out_valid  output  1  result valid.
REQ-012 result  output  64  result; meaningful only while out_valid=1.

Function
REQ-013 The FSM SHALL have states IDLE, CALC and DONE.
REQ-014 IDLE with start=1 SHALL latch the operands, op and op_w on that edge (accept cycle N) and enter CALC, or enter DONE directly for the REQ-019/REQ-020 special cases.
REQ-015 The CALC iteration counter SHALL load 64 for doubleword ops and 32 for word ops, decrement once per CALC cycle, and leave CALC when it reaches 1.
- out_valid first high in cycle N+65 for doubleword ops.
- out_valid first high in cycle N+33 for word ops.
REQ-016 Multiply SHALL use shift-add on operand magnitudes into a 128-bit accumulator, with sign correction applied on entry to DONE.
- MUL returns the low 64 bits.
- MULH (signed x signed), MULHSU (signed x unsigned) and MULHU (unsigned x unsigned) return the high 64 bits.
REQ-017 Divide SHALL use restoring division on magnitudes.
- Quotient sign = sign(A) XOR sign(B).
- Remainder sign = sign(A).
REQ-018 Word ops SHALL use inputa[31:0] and inputb[31:0] (sign- or zero-extended per signedness) and return the 32-bit result sign-extended to 64 bits.
REQ-019 Division by zero SHALL take 1 cycle (DONE at N+1).
- DIV/DIVU return all ones (width per op_w, then sign-extended).
- REM/REMU return the dividend.
REQ-020 Signed overflow (most-negative / -1, at 64 or 32 bits) SHALL take 1 cycle.
- DIV returns the dividend.
- REM returns 0.
REQ-021 In DONE, out_valid=1 and result SHALL be held stable.
- mwb_block=0: the result is consumed on that edge and the FSM returns to IDLE.
- mwb_block=1: the FSM holds in DONE indefinitely.
REQ-022 start SHALL be ignored in CALC and DONE.
- A new request is accepted no earlier than the IDLE cycle after consumption.
REQ-023 alu_busy SHALL be high in CALC and DONE and low in IDLE.
REQ-024 Operand inputs SHALL be don't-care after the accept edge.

Reset
REQ-025 While rst=1 the block SHALL enter IDLE with alu_busy=0, out_valid=0, result=0, counter=0 and accumulator=0.
REQ-026 A reset in CALC or DONE SHALL abort the operation with no result produced.
- start is accepted in the first cycle after rst deasserts.
REQ-027 rst SHALL take priority over start and mwb_block in the same cycle.

Configuration
REQ-028 YSYX_220053_MDU_FAST_MUL_EN defined: ops 0-3 SHALL compute with a single-cycle combinational multiply and enter DONE at N+1; divide timing is unchanged.
REQ-029 YSYX_220053_MDU_FAST_MUL_EN undefined: all multiplies SHALL use the iterative datapath with the REQ-015 latency.

Verification
REQ-030 MUL, A=7, B=-3, op_w=0 -> result=0xFFFFFFFFFFFFFFEB at N+65 (N+1 with the macro); alu_busy high N+1..N+65.
REQ-031 MULHU, A=B=0xFFFFFFFFFFFFFFFF -> result=0xFFFFFFFFFFFFFFFE; MULH with the same operands -> 0.
REQ-032 DIVW, A=0x80000000, B=0xFFFFFFFF -> result=0xFFFFFFFF80000000 at N+1; REMW with the same operands -> 0.
REQ-033 DIVU, A=100, B=0 -> result=0xFFFFFFFFFFFFFFFF at N+1; REM, A=-7, B=2 -> result=-1 at N+65.
REQ-034 DIV, A=100, B=7, mwb_block=1 for 10 cycles after out_valid rises -> result=14 held stable; start pulses during the hold are ignored; IDLE the cycle after mwb_block falls.
REQ-035 rst asserted at N+20 of a DIV -> alu_busy=0 and out_valid=0 the next cycle; a new REMU, A=10, B=3 -> result=1.

Source files
------------

// File: rtl/ysyx_220053_mdu.sv
// rtl/ysyx_220053_mdu.sv - iterative RV64M multiply/divide unit
//
// Purpose : shift-add multiply and restoring divide on operand magnitudes,
//           with sign correction applied when the result is written. Word
//           variants operate on the low 32 bits and sign-extend the result.
//           Divide-by-zero and signed overflow finish one cycle after accept.
// Option  : define YSYX_220053_MDU_FAST_MUL_EN to compute multiplies with a
//           single-cycle combinational product (divide timing unchanged).
// Ports   : clk        rising-edge clock
//           rst        synchronous active-high reset
//           start      request strobe, sampled only in IDLE
//           mdu_op     0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
//           op_w       word variant (ignored for ops 1-3)
//           inputa     operand A (rs1 / dividend)
//           inputb     operand B (rs2 / divisor)
//           mwb_block  downstream stall, result held while high
//           alu_busy   high in CALC and DONE
//           out_valid  result valid (DONE)
//           result     64-bit result
module ysyx_220053_mdu (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic        op_w,
  input  logic [63:0] inputa,
  input  logic [63:0] inputb,
  input  logic        mwb_block,
  output logic        alu_busy,
  output logic        out_valid,
  output logic [63:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state, state_nxt;
  logic [2:0]    op_q;
  logic          w_q;
  logic          neg_a_q, neg_b_q;
  logic [63:0]   opnd_q;     // multiplicand for mul, divisor for div
  logic [127:0]  acc_q;
  logic [6:0]    cnt_q;
  logic [63:0]   res_q;

  // ---------------- request decode / operand preparation ----------------
  logic          is_div, w_eff, sign_a, sign_b, neg_a, neg_b;
  logic [63:0]   a_ext, b_ext, ma, mb, a_w;
  logic          div0, ovf;
  logic [63:0]   spec_res;
  logic [127:0]  acc_init;

  always_comb begin
    is_div = mdu_op[2];
    w_eff  = op_w & ((mdu_op == 3'd0) | mdu_op[2]);
    sign_a = (mdu_op == 3'd0) | (mdu_op == 3'd1) | (mdu_op == 3'd2) |
             (mdu_op == 3'd4) | (mdu_op == 3'd6);
    sign_b = (mdu_op == 3'd0) | (mdu_op == 3'd1) |
             (mdu_op == 3'd4) | (mdu_op == 3'd6);
    a_ext  = w_eff ? {{32{sign_a & inputa[31]}}, inputa[31:0]} : inputa;
    b_ext  = w_eff ? {{32{sign_b & inputb[31]}}, inputb[31:0]} : inputb;
    neg_a  = sign_a & a_ext[63];
    neg_b  = sign_b & b_ext[63];
    ma     = neg_a ? -a_ext : a_ext;
    mb     = neg_b ? -b_ext : b_ext;
    // dividend as architecturally returned (word results are sign-extended)
    a_w    = w_eff ? {{32{inputa[31]}}, inputa[31:0]} : inputa;

    div0   = is_div & (b_ext == 64'd0);
    ovf    = is_div & ~mdu_op[0] &
             (w_eff ? ((inputa[31:0] == 32'h8000_0000) && (inputb[31:0] == 32'hFFFF_FFFF))
                    : ((inputa == 64'h8000_0000_0000_0000) && (inputb == 64'hFFFF_FFFF_FFFF_FFFF)));

    spec_res = 64'd0;
    if (div0)     spec_res = mdu_op[1] ? a_w : 64'hFFFF_FFFF_FFFF_FFFF;
    else if (ovf) spec_res = mdu_op[1] ? 64'd0 : a_w;

    // Divide: dividend is placed so its MSB is acc[63] on the first step;
    // word dividends sit in acc[63:32] so 32 steps consume them exactly.
    // Multiply: multiplier magnitude in the low half, consumed LSB first.
    if (is_div) acc_init = w_eff ? {64'd0, ma[31:0], 32'd0} : {64'd0, ma};
    else        acc_init = {64'd0, mb};
  end

  // Sign correction and result extraction. Word products end up in x[95:32]
  // after 32 right-shifting steps; word quotients in x[31:0].
  function automatic logic [63:0] finalize(input logic [127:0] x, input logic [2:0] op,
                                           input logic w, input logic na, input logic nb);
    logic [127:0] pd;
    logic [63:0]  pw, q, r, sel;
    begin
      pd = (na ^ nb) ? -x : x;
      pw = (na ^ nb) ? -x[95:32] : x[95:32];
      q  = (na ^ nb) ? -x[63:0] : x[63:0];
      r  = na ? -x[127:64] : x[127:64];
      if (op[2]) begin
        sel = op[1] ? r : q;
        finalize = w ? {{32{sel[31]}}, sel[31:0]} : sel;
      end else if (w) begin
        finalize = {{32{pw[31]}}, pw[31:0]};
      end else begin
        finalize = (op == 3'd0) ? pd[63:0] : pd[127:64];
      end
    end
  endfunction

`ifdef YSYX_220053_MDU_FAST_MUL_EN
  logic [127:0] fast_prod, fast_acc;
  logic [63:0]  fast_res;
  always_comb begin
    fast_prod = {64'd0, ma} * {64'd0, mb};
    fast_acc  = w_eff ? {32'd0, fast_prod[63:0], 32'd0} : fast_prod;
    fast_res  = finalize(fast_acc, mdu_op, w_eff, neg_a, neg_b);
  end
`endif

  // ---------------- one iteration step ----------------
  logic [64:0]  mul_sum;
  logic [127:0] mul_step, div_step, acc_step;
  logic [64:0]  div_r65;
  logic [63:0]  div_sub;
  logic         div_ge;

  always_comb begin
    mul_sum  = {1'b0, acc_q[127:64]} + (acc_q[0] ? {1'b0, opnd_q} : 65'd0);
    mul_step = {mul_sum, acc_q[63:1]};
    // partial remainder can reach 65 bits before the trial subtraction
    div_r65  = {acc_q[127:64], acc_q[63]};
    div_ge   = div_r65 >= {1'b0, opnd_q};
    div_sub  = div_r65[63:0] - opnd_q;
    div_step = div_ge ? {div_sub, acc_q[62:0], 1'b1}
                      : {div_r65[63:0], acc_q[62:0], 1'b0};
    acc_step = op_q[2] ? div_step : mul_step;
  end

  // ---------------- FSM ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (div0 | ovf) state_nxt = DONE;
`ifdef YSYX_220053_MDU_FAST_MUL_EN
          else if (!is_div) state_nxt = DONE;
`endif
          else state_nxt = CALC;
        end
      end
      CALC:    if (cnt_q == 7'd1) state_nxt = DONE;
      DONE:    if (!mwb_block) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= 3'd0;
      w_q     <= 1'b0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      opnd_q  <= 64'd0;
      acc_q   <= 128'd0;
      cnt_q   <= 7'd0;
      res_q   <= 64'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            op_q    <= mdu_op;
            w_q     <= w_eff;
            neg_a_q <= neg_a;
            neg_b_q <= neg_b;
            opnd_q  <= is_div ? mb : ma;
            acc_q   <= acc_init;
            cnt_q   <= w_eff ? 7'd32 : 7'd64;
            if (div0 | ovf) res_q <= spec_res;
`ifdef YSYX_220053_MDU_FAST_MUL_EN
            else if (!is_div) res_q <= fast_res;
`endif
          end
        end
        CALC: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q - 7'd1;
          if (cnt_q == 7'd1) res_q <= finalize(acc_step, op_q, w_q, neg_a_q, neg_b_q);
        end
        default: ;
      endcase
    end
  end

  assign alu_busy  = (state != IDLE);
  assign out_valid = (state == DONE);
  assign result    = res_q;

endmodule

// File: tb/tb_ysyx_220053_mdu.sv
// tb/tb_ysyx_220053_mdu.sv - directed self-checking bench for ysyx_220053_mdu
module tb_ysyx_220053_mdu;

  logic        clk = 1'b0;
  logic        rst, start, op_w, mwb_block;
  logic [2:0]  mdu_op;
  logic [63:0] inputa, inputb, result;
  logic        alu_busy, out_valid;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef YSYX_220053_MDU_FAST_MUL_EN
  localparam int MUL_LAT  = 1;
  localparam int MULW_LAT = 1;
`else
  localparam int MUL_LAT  = 65;
  localparam int MULW_LAT = 33;
`endif

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  always #5 clk = ~clk;

  ysyx_220053_mdu dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mdu_op    (mdu_op),
    .op_w      (op_w),
    .inputa    (inputa),
    .inputb    (inputb),
    .mwb_block (mwb_block),
    .alu_busy  (alu_busy),
    .out_valid (out_valid),
    .result    (result)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; issues one request and follows it to consumption.
  task automatic run_op(input string tag, input logic [2:0] op, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input int exp_lat, input logic [63:0] exp_res);
    int lat;
    int busy_bad;
    mdu_op = op; op_w = w; inputa = a; inputb = b; start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    inputa = {$urandom, $urandom};
    inputb = {$urandom, $urandom};
    lat = 0; busy_bad = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (!alu_busy) busy_bad++;
      if (out_valid) break;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"}, result, exp_res);
    check({tag, "_busy"}, 64'(busy_bad), 64'd0);
    @(negedge clk);
    check({tag, "_idle"}, {62'd0, alu_busy, out_valid}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    rst = 1'b1; start = 1'b0; op_w = 1'b0; mwb_block = 1'b0;
    mdu_op = 3'd0; inputa = 64'd0; inputb = 64'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy_valid", {62'd0, alu_busy, out_valid}, 64'd0);
    check("reset_result", result, 64'd0);
    rst = 1'b0;

    run_op("mul_7_m3",   3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, MUL_LAT, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("mulhu_ones", 3'd3, 1'b0, ONES, ONES, MUL_LAT, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("mulh_ones",  3'd1, 1'b0, ONES, ONES, MUL_LAT, 64'd0);
    run_op("mulw",       3'd0, 1'b1, 64'hDEAD_0000_7FFF_FFFF, 64'd2, MULW_LAT, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("mulhsu_w",   3'd2, 1'b1, ONES, 64'd2, MUL_LAT, ONES);
    run_op("mul_big",    3'd0, 1'b0, 64'h0000_0001_0000_0001, 64'h0000_0001_0000_0001,
           MUL_LAT, 64'h0000_0002_0000_0001);
    run_op("divw_ovf",   3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 1, 64'hFFFF_FFFF_8000_0000);
    run_op("remw_ovf",   3'd6, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 1, 64'd0);
    run_op("div_ovf64",  3'd4, 1'b0, 64'h8000_0000_0000_0000, ONES, 1, 64'h8000_0000_0000_0000);
    run_op("divu_zero",  3'd5, 1'b0, 64'd100, 64'd0, 1, ONES);
    run_op("divw_zero",  3'd4, 1'b1, 64'd5, 64'hFFFF_FFFF_0000_0000, 1, ONES);
    run_op("remuw_zero", 3'd7, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0000, 1,
           64'hFFFF_FFFF_9ABC_DEF0);
    run_op("rem_m7_2",   3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65, ONES);
    run_op("div_m100_7", 3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 65, 64'hFFFF_FFFF_FFFF_FFF2);
    run_op("remw_m100",  3'd6, 1'b1, 64'h0000_0000_FFFF_FF9C, 64'd7, 33, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("divuw",      3'd5, 1'b1, ONES, 64'hFFFF_FFFF_0000_0002, 33, 64'h0000_0000_7FFF_FFFF);
    run_op("divu_big",   3'd5, 1'b0, ONES, 64'h8000_0000_0000_0001, 65, 64'd1);
    run_op("remu_big",   3'd7, 1'b0, ONES, 64'h8000_0000_0000_0001, 65, 64'h7FFF_FFFF_FFFF_FFFE);

    // stall: result held for 10 cycles, start pulses ignored
    mwb_block = 1'b1;
    mdu_op = 3'd4; op_w = 1'b0; inputa = 64'd100; inputb = 64'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    bad = 0;
    while (bad < 200) begin
      @(negedge clk);
      bad++;
      if (out_valid) break;
    end
    check("stall_lat", 64'(bad), 64'd65);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!out_valid || result !== 64'd14) bad++;
      start  = (i % 2 == 0);
      mdu_op = 3'd5; inputa = 64'd0; inputb = 64'd0;
      @(negedge clk);
    end
    start = 1'b0;
    check("stall_hold", 64'(bad), 64'd0);
    check("stall_res", result, 64'd14);
    check("stall_valid", {63'd0, out_valid}, 64'd1);
    mwb_block = 1'b0;
    @(negedge clk);
    check("stall_release_idle", {62'd0, alu_busy, out_valid}, 64'd0);

    // reset abort in the middle of a divide
    mdu_op = 3'd4; op_w = 1'b0; inputa = 64'd100; inputb = 64'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_busy_before", {63'd0, alu_busy}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy_valid", {62'd0, alu_busy, out_valid}, 64'd0);
    check("abort_result", result, 64'd0);
    rst = 1'b0;
    run_op("remu_after_rst", 3'd7, 1'b0, 64'd10, 64'd3, 65, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
